// File: rtl/ex_div.sv
// ex_div: 32-bit restoring divider for the execute stage (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Build option DIV_FAST_SPECIAL_EN: a zero divisor or signed overflow finishes straight from DIV_FREE.
//
// state    | meaning
// DIV_FREE | idle, accepts div_start when div_cancel is low
// DIV_ON   | 32 shift-subtract steps, abortable by div_cancel
// DIV_END  | result registered, div_ready high for this one cycle
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        div_rem,
  input  logic [31:0] div_op1,
  input  logic [31:0] div_op2,
  input  logic        div_cancel,
  output logic [31:0] div_result,
  output logic        div_ready,
  output logic        div_stallreq
);

  typedef enum logic [1:0] {
    DIV_FREE = 2'd0,
    DIV_ON   = 2'd1,
    DIV_END  = 2'd2
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] dsor_q, dsor_d;
  logic [31:0] op1_q, op1_d;
  logic        op2_neg_q, op2_neg_d;
  logic        sgn_q, sgn_d;
  logic        sel_rem_q, sel_rem_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        op1_neg, op2_neg;
  logic [31:0] op1_abs, op2_abs;
  logic [32:0] hi_shift, trial;
  logic        take;
  logic [64:0] acc_step;
  logic [31:0] quo_fix, rem_fix, final_val;
  logic        lat_zero, lat_ovf;

  assign op1_neg = div_signed & div_op1[31];
  assign op2_neg = div_signed & div_op2[31];
  assign op1_abs = op1_neg ? -div_op1 : div_op1;
  assign op2_abs = op2_neg ? -div_op2 : div_op2;

  // acc_q[64] stays 0 after every step but is honoured so the compare covers the whole register
  assign hi_shift = acc_q[63:31];
  assign take     = acc_q[64] | (hi_shift >= {1'b0, dsor_q});
  assign trial    = hi_shift - {1'b0, dsor_q};
  assign acc_step = take ? {trial, acc_q[30:0], 1'b1} : {acc_q[63:0], 1'b0};

  assign lat_zero = (dsor_q == 32'd0);
  assign lat_ovf  = sgn_q && op1_q == 32'h8000_0000 && op2_neg_q && dsor_q == 32'd1;

  always_comb begin
    quo_fix = acc_step[31:0];
    rem_fix = acc_step[63:32];
    if (sgn_q && (op1_q[31] ^ op2_neg_q)) quo_fix = -acc_step[31:0];
    if (sgn_q && op1_q[31])               rem_fix = -acc_step[63:32];
    if (lat_zero) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = op1_q;
    end else if (lat_ovf) begin
      quo_fix = 32'h8000_0000;
      rem_fix = 32'h0000_0000;
    end
    final_val = sel_rem_q ? rem_fix : quo_fix;
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic        in_zero, in_ovf;
  logic [31:0] fast_val;
  assign in_zero  = (div_op2 == 32'd0);
  assign in_ovf   = div_signed && div_op1 == 32'h8000_0000 && div_op2 == 32'hFFFF_FFFF;
  assign fast_val = in_zero ? (div_rem ? div_op1 : 32'hFFFF_FFFF)
                            : (div_rem ? 32'h0000_0000 : 32'h8000_0000);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dsor_d    = dsor_q;
    op1_d     = op1_q;
    op2_neg_d = op2_neg_q;
    sgn_d     = sgn_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    case (state_q)
      DIV_FREE: begin
        if (div_start && !div_cancel) begin
          acc_d     = {33'd0, op1_abs};
          dsor_d    = op2_abs;
          op1_d     = div_op1;
          op2_neg_d = op2_neg;
          sgn_d     = div_signed;
          sel_rem_d = div_rem;
          cnt_d     = 6'd0;
          state_d   = DIV_ON;
`ifdef DIV_FAST_SPECIAL_EN
          if (in_zero || in_ovf) begin
            state_d  = DIV_END;
            result_d = fast_val;
            ready_d  = 1'b1;
          end
`endif
        end
      end
      DIV_ON: begin
        if (div_cancel) begin
          state_d = DIV_FREE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = DIV_END;
            result_d = final_val;
            ready_d  = 1'b1;
          end
        end
      end
      DIV_END: state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= 6'd0;
      acc_q     <= 65'd0;
      dsor_q    <= 32'd0;
      op1_q     <= 32'd0;
      op2_neg_q <= 1'b0;
      sgn_q     <= 1'b0;
      sel_rem_q <= 1'b0;
      result_q  <= 32'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dsor_q    <= dsor_d;
      op1_q     <= op1_d;
      op2_neg_q <= op2_neg_d;
      sgn_q     <= sgn_d;
      sel_rem_q <= sel_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign div_result   = result_q;
  assign div_ready    = ready_q;
  assign div_stallreq = !rst && ((state_q == DIV_FREE && div_start && !div_cancel) ||
                                 state_q == DIV_ON);

endmodule
